// File: rtl/tx_frame_sequencer_if.sv
// Host/transmitter-side bundle for tx_frame_sequencer: FIFO write port, frame control,
// send/rdy byte handshake and status.
interface tx_frame_sequencer_if #(
   parameter int DEPTH = 32
);
   localparam int CW = $clog2(DEPTH + 1);

   logic          wr_en;
   logic [7:0]    wr_data;
   logic          xsend;
   logic          tx_rdy;
   logic          tx_send;
   logic [7:0]    tx_data;
   logic          busy;
   logic          full;
   logic          empty;
   logic [CW-1:0] count;
   logic          overflow;
   logic          frame_done;

   // master: the host plus the transmitter's rdy; slave: the sequencer
   modport master (
      output wr_en, wr_data, xsend, tx_rdy,
      input  tx_send, tx_data, busy, full, empty, count, overflow, frame_done
   );

   modport slave (
      input  wr_en, wr_data, xsend, tx_rdy,
      output tx_send, tx_data, busy, full, empty, count, overflow, frame_done
   );
endinterface

// File: rtl/tx_frame_sequencer.sv
// Buffers payload bytes and emits preamble, SFD, then the bytes queued at xsend time,
// one byte per send/rdy transfer with no bubbles; frame_done pulses as tx_send drops.
module tx_frame_sequencer #(
   parameter int         DEPTH     = 32,
   parameter int         PRE_BYTES = 2,
   parameter logic [7:0] PRE_VAL   = 8'h55,
   parameter logic [7:0] SFD_VAL   = 8'hD0
) (
   input  logic                 clk,
   input  logic                 reset,
   tx_frame_sequencer_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (PRE_BYTES > 1) ? $clog2(PRE_BYTES) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_PRE  = 2'd1;
   localparam logic [1:0] S_SFD  = 2'd2;
   localparam logic [1:0] S_DATA = 2'd3;

   logic [1:0]    state_q,      state_d;
   logic [PW-1:0] pre_cnt_q,    pre_cnt_d;
   logic [CW-1:0] rem_q,        rem_d;
   logic [CW-1:0] count_q,      count_d;
   logic [AW-1:0] wr_ptr_q,     wr_ptr_d;
   logic [AW-1:0] rd_ptr_q,     rd_ptr_d;
   logic          tx_send_q,    tx_send_d;
   logic [7:0]    tx_data_q,    tx_data_d;
   logic          overflow_q,   overflow_d;
   logic          frame_done_q, frame_done_d;
   logic [7:0]    mem_q [DEPTH];

   logic xfer;
   logic pop;
   logic push;

   always_comb begin
      state_d      = state_q;
      pre_cnt_d    = pre_cnt_q;
      rem_d        = rem_q;
      tx_send_d    = tx_send_q;
      tx_data_d    = tx_data_q;
      frame_done_d = 1'b0;
      pop          = 1'b0;
      xfer         = tx_send_q && bus.tx_rdy;

      case (state_q)
         S_IDLE: begin
            // len is the count seen now; a write in this same cycle belongs to the next frame
            if (bus.xsend && count_q != '0) begin
               state_d   = S_PRE;
               tx_send_d = 1'b1;
               tx_data_d = PRE_VAL;
               pre_cnt_d = '0;
               rem_d     = count_q;
            end
         end
         S_PRE: begin
            if (xfer) begin
               if (pre_cnt_q == PW'(PRE_BYTES - 1)) begin
                  state_d   = S_SFD;
                  tx_data_d = SFD_VAL;
               end else begin
                  pre_cnt_d = pre_cnt_q + PW'(1);
               end
            end
         end
         S_SFD: begin
            if (xfer) begin
               state_d   = S_DATA;
               tx_data_d = mem_q[rd_ptr_q];
               pop       = 1'b1;
            end
         end
         default: begin
            // rem counts payload bytes not yet accepted, including the one on tx_data
            if (xfer) begin
               if (rem_q == CW'(1)) begin
                  state_d      = S_IDLE;
                  tx_send_d    = 1'b0;
                  frame_done_d = 1'b1;
               end else begin
                  rem_d     = rem_q - CW'(1);
                  tx_data_d = mem_q[rd_ptr_q];
                  pop       = 1'b1;
               end
            end
         end
      endcase

      // a pop in the same cycle frees the slot, so a write into a full FIFO still lands
      push       = bus.wr_en && (count_q != CW'(DEPTH) || pop);
      overflow_d = bus.wr_en && !push;

      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         pre_cnt_q    <= '0;
         rem_q        <= '0;
         count_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         tx_send_q    <= 1'b0;
         tx_data_q    <= 8'h00;
         overflow_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pre_cnt_q    <= pre_cnt_d;
         rem_q        <= rem_d;
         count_q      <= count_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         tx_send_q    <= tx_send_d;
         tx_data_q    <= tx_data_d;
         overflow_q   <= overflow_d;
         frame_done_q <= frame_done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= bus.wr_data;
      end
   end

   assign bus.tx_send    = tx_send_q;
   assign bus.tx_data    = tx_data_q;
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.full       = (count_q == CW'(DEPTH));
   assign bus.empty      = (count_q == '0);
   assign bus.count      = count_q;
   assign bus.overflow   = overflow_q;
   assign bus.frame_done = frame_done_q;
endmodule
